// File: rtl/hilo_div_sequencer.sv
// hilo_div_sequencer: multi-cycle unsigned restoring divider feeding HI/LO.
// A divide runs one shift-subtract step per cycle, then commits
// remainder->HI and quotient->LO. The pipeline is stalled while a
// second DIVU or an MFHI/MFLO waits on a divide that is in flight.
module hilo_div_sequencer #(
  parameter int DIV_W = 32
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             start,
  input  logic [DIV_W-1:0] dividend,
  input  logic [DIV_W-1:0] divisor,
  input  logic             flush,
  input  logic             hilo_rd,
  output logic             busy,
  output logic             stall,
  output logic [DIV_W-1:0] hi,
  output logic [DIV_W-1:0] lo,
  output logic             div_zero
);
  localparam int CW = $clog2(DIV_W) + 1;

  typedef enum logic [1:0] {IDLE, RUN, DONE} state_t;

  state_t           state, state_nx;
  logic [CW-1:0]    cnt;
  logic [DIV_W-1:0] rem, quo, dvs;
  logic [DIV_W:0]   trial;
  logic             ge;
  logic [DIV_W-1:0] rem_nx;
  logic             last_step;

  // One restoring step: shift the quotient MSB into the partial remainder,
  // then subtract the divisor if it fits. The extra trial bit keeps the
  // comparison exact when the shifted remainder overflows DIV_W bits.
  assign trial     = {rem, quo[DIV_W-1]};
  assign ge        = trial >= {1'b0, dvs};
  assign last_step = (cnt == CW'(DIV_W - 1));

  // Remainder update for the current step (a zero divisor always "fits",
  // which yields an all-ones quotient and the dividend as remainder).
  always_comb begin
    rem_nx = trial[DIV_W-1:0];
    if (ge) rem_nx = DIV_W'(trial - {1'b0, dvs});
  end

  // State register.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) state <= IDLE;
    else     state <= state_nx;
  end

  // Next-state logic; flush wins over start and aborts any in-flight divide.
  always_comb begin
    state_nx = state;
    case (state)
      IDLE:    if (start && !flush) state_nx = RUN;
      RUN:     if (flush) state_nx = IDLE;
               else if (last_step) state_nx = DONE;
      DONE:    state_nx = IDLE;
      default: state_nx = IDLE;
    endcase
  end

  // Datapath: operand capture, iteration, and HI/LO commit.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      cnt      <= '0;
      rem      <= '0;
      quo      <= '0;
      dvs      <= '0;
      hi       <= '0;
      lo       <= '0;
      div_zero <= 1'b0;
    end else begin
      case (state)
        IDLE: if (start && !flush) begin
          rem <= '0;
          quo <= dividend;
          dvs <= divisor;
          cnt <= '0;
        end
        RUN: if (!flush) begin
          rem <= rem_nx;
          quo <= {quo[DIV_W-2:0], ge};
          cnt <= cnt + CW'(1);
        end
        DONE: if (!flush) begin
          hi       <= rem;
          lo       <= quo;
          div_zero <= (dvs == '0);
        end
        default: ;
      endcase
    end
  end

  assign busy  = (state != IDLE);
  assign stall = busy && (hilo_rd || start);

endmodule

// File: tb/tb_hilo_div_sequencer.sv
// Bench for hilo_div_sequencer: directed divides with hand-computed results.
// The driver pushes the expected HI/LO/div_zero (and busy length) into a
// scoreboard; a monitor pops and compares whenever busy falls.
module tb_hilo_div_sequencer;
  localparam int W = 32;

  logic         clk = 1'b0;
  logic         rst = 1'b1;
  logic         start = 1'b0;
  logic [W-1:0] dividend = '0;
  logic [W-1:0] divisor = '0;
  logic         flush = 1'b0;
  logic         hilo_rd = 1'b0;
  logic         busy, stall, div_zero;
  logic [W-1:0] hi, lo;

  hilo_div_sequencer #(.DIV_W(W)) dut (
    .clk(clk), .rst(rst), .start(start), .dividend(dividend),
    .divisor(divisor), .flush(flush), .hilo_rd(hilo_rd), .busy(busy),
    .stall(stall), .hi(hi), .lo(lo), .div_zero(div_zero)
  );

  always #5 clk = ~clk;

  typedef struct {
    logic [W-1:0] hi;
    logic [W-1:0] lo;
    logic         dz;
    int           cyc;  // expected busy cycles, 0 = don't care
  } exp_t;

  exp_t sb[$];
  int   checks = 0;
  int   errors = 0;

  task automatic chk(input string name, input logic [W-1:0] act, input logic [W-1:0] req);
    checks++;
    if (act !== req) begin
      errors++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", name, act, req);
    end
  endtask

  // Monitor: on each busy falling edge, compare HI/LO against the next entry.
  logic prev_busy = 1'b0;
  int   bcyc = 0;
  always @(negedge clk) begin
    exp_t e;
    if (busy) bcyc++;
    if (prev_busy && !busy) begin
      if (sb.size() == 0) begin
        checks++; errors++;
        $display("FAIL sb_empty: completion with no expected entry");
      end else begin
        e = sb.pop_front();
        chk("mon_hi", hi, e.hi);
        chk("mon_lo", lo, e.lo);
        chk("mon_dz", W'(div_zero), W'(e.dz));
        if (e.cyc != 0) chk("mon_busy_cycles", W'(bcyc), W'(e.cyc));
      end
      bcyc = 0;
    end
    prev_busy = busy;
  end

  task automatic push(input logic [W-1:0] h, input logic [W-1:0] l, input logic dz, input int cyc);
    exp_t e;
    e.hi = h; e.lo = l; e.dz = dz; e.cyc = cyc;
    sb.push_back(e);
  endtask

  task automatic do_start(input logic [W-1:0] a, input logic [W-1:0] b);
    @(negedge clk);
    dividend = a; divisor = b; start = 1'b1;
    @(posedge clk); #1 start = 1'b0;
  endtask

  task automatic wait_idle(input string name);
    int n;
    n = 0;
    while (busy && n < 100) begin @(negedge clk); n++; end
    if (busy) begin
      checks++; errors++;
      $display("FAIL %s: timeout waiting for idle, busy=%0b", name, busy);
    end
    @(negedge clk);
  endtask

  initial begin
    // Reset state
    #3;
    chk("rst_busy", W'(busy), '0);
    chk("rst_stall", W'(stall), '0);
    chk("rst_hi", hi, '0);
    chk("rst_lo", lo, '0);
    @(negedge clk); rst = 1'b0;

    // 100/7 started on the first edge after reset release
    push(32'd2, 32'd14, 1'b0, 33);
    dividend = 32'd100; divisor = 32'd7; start = 1'b1;
    @(posedge clk); #1 start = 1'b0;
    chk("start_after_rst_busy", W'(busy), 32'd1);
    wait_idle("div_100_7");

    // Divide by zero
    push(32'h12345678, 32'hFFFFFFFF, 1'b1, 33);
    do_start(32'h12345678, 32'd0);
    wait_idle("div_zero");

    // MFHI/MFLO held from step 5: stall until idle, then new quotient visible
    push(32'd6, 32'd142, 1'b0, 33);
    do_start(32'd1000, 32'd7);
    repeat (4) @(posedge clk);
    @(negedge clk); hilo_rd = 1'b1;
    #1 chk("hilo_stall_run", W'(stall), 32'd1);
    begin
      int n;
      n = 0;
      while (busy && n < 100) begin
        @(negedge clk); n++;
        if (busy) chk("hilo_stall_run", W'(stall), 32'd1);
      end
    end
    chk("hilo_stall_idle", W'(stall), '0);
    chk("hilo_lo_new", lo, 32'd142);
    hilo_rd = 1'b0;
    @(negedge clk);

    // Set hi=3, lo=9, then flush a divide at step 10
    push(32'd3, 32'd9, 1'b0, 33);
    do_start(32'd57, 32'd6);
    wait_idle("div_57_6");
    push(32'd3, 32'd9, 1'b0, 10);
    do_start(32'd500, 32'd4);
    repeat (9) @(posedge clk);
    @(negedge clk); flush = 1'b1;
    @(posedge clk); #1 flush = 1'b0;
    chk("flush_busy", W'(busy), '0);
    chk("flush_hi", hi, 32'd3);
    chk("flush_lo", lo, 32'd9);
    wait_idle("flush");

    // Flush has priority over start in IDLE
    @(negedge clk); start = 1'b1; flush = 1'b1;
    @(posedge clk); #1 start = 1'b0; flush = 1'b0;
    chk("flush_prio_busy", W'(busy), '0);
    @(negedge clk);

    // Async reset at step 20, then a clean divide
    push(32'd0, 32'd0, 1'b0, 0);
    do_start(32'd200, 32'd9);
    repeat (19) @(posedge clk);
    hilo_rd = 1'b1;
    #2 rst = 1'b1;
    #1;
    chk("midrst_busy", W'(busy), '0);
    chk("midrst_stall", W'(stall), '0);
    chk("midrst_hi", hi, '0);
    chk("midrst_lo", lo, '0);
    #1 rst = 1'b0; hilo_rd = 1'b0;
    @(negedge clk);
    push(32'd2, 32'd22, 1'b0, 33);
    do_start(32'd200, 32'd9);
    wait_idle("div_200_9");

    // 0xFFFFFFFF/1 with a second DIVU holding start during RUN
    push(32'd0, 32'hFFFFFFFF, 1'b0, 33);
    push(32'd10, 32'd30, 1'b0, 33);
    @(negedge clk);
    dividend = 32'hFFFFFFFF; divisor = 32'd1; start = 1'b1;
    @(posedge clk);
    @(negedge clk);
    dividend = 32'd1000; divisor = 32'd33;
    begin
      int n;
      n = 0;
      while (busy && n < 100) begin
        chk("held_start_stall", W'(stall), 32'd1);
        @(negedge clk); n++;
      end
    end
    chk("held_first_lo", lo, 32'hFFFFFFFF);
    chk("held_first_hi", hi, '0);
    @(posedge clk); #1 start = 1'b0;
    chk("held_second_busy", W'(busy), 32'd1);
    wait_idle("held_second");

    chk("sb_drained", W'(sb.size()), '0);
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1);
  end
endmodule
